// File: rtl/board_input_conditioner.sv
// Board input conditioner: synchronizes and debounces the 5 push buttons, with press pulses.
// Define BOARD_INPUT_SW_DEBOUNCE_EN to debounce the 16 slide switches too; otherwise they are only synchronized.

module board_input_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [1:0][W-1:0] sync_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[0], din};
  end

  assign dout = sync_pipe[1];
endmodule

module board_input_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);
  typedef enum logic {IDLE, CHECK} state_t;

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             synced, stable, stable_nxt, rise_nxt, diff;

  board_input_sync #(.W(1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .dout (synced)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      stable <= stable_nxt;
      rise   <= rise_nxt;
    end
  end

  // The first differing cycle already counts, so an unbroken change commits
  // DEBOUNCE_CYCLES edges after it leaves the synchronizer.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = '0;
    stable_nxt = stable;
    rise_nxt   = 1'b0;
    diff       = synced ^ stable;
    case (state)
      IDLE: begin
        if (diff) begin
          cnt_nxt   = CNT_W'(1);
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (!diff) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_TERM) begin
          stable_nxt = synced;
          rise_nxt   = synced;
          state_nxt  = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign level = stable;
endmodule

module board_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  btn_in,
  input  logic [15:0] sw_in,
  output logic [4:0]  btn_level,
  output logic [4:0]  btn_press,
  output logic [15:0] sw_out
);
  localparam int NUM_BTN = 5;
  localparam int NUM_SW  = 16;

  genvar i;
  generate
    for (i = 0; i < NUM_BTN; i++) begin : g_btn
      board_input_debounce_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_lane (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (btn_in[i]),
        .level(btn_level[i]),
        .rise (btn_press[i])
      );
    end
  endgenerate

`ifdef BOARD_INPUT_SW_DEBOUNCE_EN
  // Switches have no consumer for edge pulses.
  logic [NUM_SW-1:0] sw_rise_unused;

  generate
    for (i = 0; i < NUM_SW; i++) begin : g_sw
      board_input_debounce_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_lane (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (sw_in[i]),
        .level(sw_out[i]),
        .rise (sw_rise_unused[i])
      );
    end
  endgenerate
`else
  board_input_sync #(.W(NUM_SW)) u_sw_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sw_in),
    .dout (sw_out)
  );
`endif
endmodule

// File: doc/board_input_conditioner.md
BOARD_INPUT_CONDITIONER -- requirements
Module: board_input_conditioner

Interface
- REQ-001: Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the stable-input time in clk cycles (10 ms at 100 MHz); legal minimum 2.
- REQ-002: Parameter CNT_W, default $clog2(DEBOUNCE_CYCLES), SHALL set the per-input counter width.
- REQ-003: clk  input  1  SHALL be the single clock; all state SHALL be clocked on its rising edge.
- REQ-004: rst_n  input  1  SHALL be the asynchronous, active-low reset.
- REQ-005: btn_in  input  5  SHALL carry raw asynchronous buttons; bit order [0]=C, [1]=U, [2]=L, [3]=R, [4]=D.
- REQ-006: sw_in  input  16  SHALL carry raw asynchronous slide switches.
- REQ-007: btn_level  output  5  SHALL give the debounced button levels.
- REQ-008: btn_press  output  5  SHALL give a one-cycle pulse per debounced 0->1 button transition.
- REQ-009: sw_out  output  16  SHALL give the conditioned switch levels for the CPU top level.

Function
- REQ-010: Each input bit SHALL pass through a 2-flop synchronizer before any other logic.
- REQ-011: Each debounced bit SHALL have a private counter and a stable register, and SHALL behave as a 2-state FSM: IDLE (synced == stable, counter held at 0) and CHECK (synced != stable).
- REQ-012: In CHECK, the counter SHALL increment by 1 per cycle while synced differs from stable.
- REQ-013: In CHECK, when counter == DEBOUNCE_CYCLES-1 and synced still differs, the next edge SHALL load stable with synced, clear the counter and return to IDLE.
- REQ-014: If synced returns equal to stable before terminal count, the counter SHALL clear on the next edge with no output change; bounces therefore restart the timing.
- REQ-015: Latency from a clean input change to the output change SHALL be exactly DEBOUNCE_CYCLES+2 rising edges.
- REQ-016: btn_press[i] SHALL be registered, SHALL assert in the same cycle btn_level[i] goes 0->1, and SHALL deassert after exactly one cycle.
- REQ-017: A 1->0 button transition SHALL produce no pulse on btn_press.
- REQ-018: Each bit SHALL be independent, so simultaneous changes on several bits SHALL each follow REQ-011..REQ-017 without interaction.
- REQ-019: The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.

Reset
- REQ-020: While rst_n = 0, all synchronizer flops, counters, stable registers, btn_level, btn_press and sw_out SHALL be 0 immediately, regardless of clk.
- REQ-021: After rst_n deasserts, an input already held at 1 SHALL be treated as a fresh 0->1 transition, so a held button SHALL produce one btn_press pulse.
- REQ-022: Reset during CHECK SHALL abandon the debounce and SHALL emit no pulse for the interrupted transition.

Configuration
- REQ-023: Macro BOARD_INPUT_SW_DEBOUNCE_EN SHALL select the switch path.
- REQ-024: With BOARD_INPUT_SW_DEBOUNCE_EN defined, each sw_in bit SHALL use the full debounce of REQ-011..REQ-015, giving a latency of DEBOUNCE_CYCLES+2.
- REQ-025: Without BOARD_INPUT_SW_DEBOUNCE_EN, sw_out SHALL be the 2-flop synchronizer output with a latency of 2 edges, and no switch counters SHALL be built.
- REQ-026: Button behaviour SHALL be identical with and without the macro.

Verification (DEBOUNCE_CYCLES=4, 10 ns clk)
- REQ-027: Hold rst_n=0 with btn_in=5'h1F and sw_in=16'h00ff -> all outputs read 0; release reset -> btn_press=5'h1F for exactly one cycle on the 6th edge.
- REQ-028: Clean rise on btn_in[0] held for 20 cycles -> btn_level[0]=1 and btn_press[0]=1 on the 6th edge; btn_press[0]=0 on the 7th edge.
- REQ-029: Toggle btn_in[1] every 2 cycles for 20 cycles, then hold 1 -> no output activity during the bounce; btn_level[1] rises on the 6th edge after the last toggle; exactly one btn_press[1] pulse.
- REQ-030: Release btn_in[0] after REQ-028 -> btn_level[0]=0 on the 6th edge; btn_press stays 5'h00.
- REQ-031: Change sw_in from 16'h00ff to 16'hff00 -> sw_out=16'hff00 on the 6th edge with the macro defined, and on the 2nd edge without it.
- REQ-032: Assert rst_n=0 asynchronously (mid-cycle) while btn_in[2] is in CHECK with counter=2 -> outputs clear immediately; after reset, hold btn_in[2]=0 -> no btn_press[2] pulse.
